// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    CLOSE    = 2'd3
  } gate_state_t;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam int DEF_CAPACITY = 9;

endpackage

// File: rtl/parking_rr_arbiter.sv
// Two-way round-robin between entry (bit 0) and exit (bit 1).
// On a tie the lane opposite to the last served direction wins.
module parking_rr_arbiter
  import parking_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_dir,
  output logic [1:0] gnt
);

  // One-hot grant; a single requester always wins outright
  always_comb begin
    gnt = req;
    if (req == 2'b11)
      gnt = (last_dir == DIR_EXIT) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate controller: arbitrates entry/exit lanes, times the
// open window, and tracks lot occupancy.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_done,
  output logic             gate_open,
  output logic             gate_dir,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             entry_deny,
  output logic             timeout_err,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  localparam int WIN_W = $clog2(OPEN_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(OPEN_CYCLES - 1);

  gate_state_t      state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             last_dir_q, last_dir_d;
  logic             gate_open_q, gate_open_d;
  logic             gate_dir_q, gate_dir_d;
  logic             entry_grant_q, entry_grant_d;
  logic             exit_grant_q, exit_grant_d;
  logic             timeout_err_q, timeout_err_d;
  logic [1:0]       gnt;

  assign full  = (occ_q == CNT_W'(CAPACITY));
  assign empty = (occ_q == '0);

  // Lanes are gated by lot state so occupancy can never wrap
  parking_rr_arbiter u_rr (
    .req      ({exit_req & ~empty, entry_req & ~full}),
    .last_dir (last_dir_q),
    .gnt      (gnt)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    occ_d         = occ_q;
    last_dir_d    = last_dir_q;
    gate_open_d   = gate_open_q;
    gate_dir_d    = gate_dir_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        if (gnt[0]) begin
          state_d       = OPEN_IN;
          entry_grant_d = 1'b1;
          gate_open_d   = 1'b1;
          gate_dir_d    = DIR_ENTRY;
          last_dir_d    = DIR_ENTRY;
        end else if (gnt[1]) begin
          state_d      = OPEN_OUT;
          exit_grant_d = 1'b1;
          gate_open_d  = 1'b1;
          gate_dir_d   = DIR_EXIT;
          last_dir_d   = DIR_EXIT;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if (pass_done) begin
          occ_d       = (state_q == OPEN_IN) ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
          state_d     = CLOSE;
          gate_open_d = 1'b0;
        end else if (win_cnt_q == WIN_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = CLOSE;
          gate_open_d   = 1'b0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset closes the gate immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      occ_q         <= '0;
      last_dir_q    <= DIR_EXIT;
      gate_open_q   <= 1'b0;
      gate_dir_q    <= DIR_ENTRY;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      occ_q         <= occ_d;
      last_dir_q    <= last_dir_d;
      gate_open_q   <= gate_open_d;
      gate_dir_q    <= gate_dir_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gate_open   = gate_open_q;
  assign gate_dir    = gate_dir_q;
  assign entry_grant = entry_grant_q;
  assign exit_grant  = exit_grant_q;
  assign timeout_err = timeout_err_q;
  assign occupancy   = occ_q;
  assign entry_deny  = (state_q == IDLE) && entry_req && full;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench for parking_gate_arbiter: the driver predicts each grant,
// timeout and open-window length from a lot model; a monitor checks them.
module tb_parking_gate_arbiter;

  localparam int CAP  = 9;
  localparam int CW   = 4;
  localparam int OPEN = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic entry_req = 1'b0, exit_req = 1'b0, pass_done = 1'b0;
  logic gate_open, gate_dir, entry_grant, exit_grant, entry_deny, timeout_err, full, empty;
  logic [CW-1:0] occupancy;

  parking_gate_arbiter #(.CAPACITY(CAP), .CNT_W(CW), .OPEN_CYCLES(OPEN)) dut (
    .clk(clk), .reset_n(reset_n), .entry_req(entry_req), .exit_req(exit_req),
    .pass_done(pass_done), .gate_open(gate_open), .gate_dir(gate_dir),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .entry_deny(entry_deny),
    .timeout_err(timeout_err), .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // kind: 1 = entry grant, 2 = exit grant, 4 = timeout
  typedef struct { int kind; int occ; } ev_t;
  ev_t ev_q[$];
  int  len_q[$];

  int n_chk = 0, n_fail = 0;
  int m_occ = 0;   // cars in lot
  int m_last = 1;  // last served lane: 0 entry, 1 exit

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected events whenever the DUT pulses one, and measures windows
  int   mon_run = 0;
  int   mon_kind;
  ev_t  mon_e;
  always @(negedge clk) begin
    if (!reset_n) mon_run = 0;
    else begin
      if (entry_grant || exit_grant || timeout_err) begin
        mon_kind = 32'(entry_grant) + 2 * 32'(exit_grant) + 4 * 32'(timeout_err);
        if (ev_q.size() == 0) chk("unexpected_event", mon_kind, 0);
        else begin
          mon_e = ev_q.pop_front();
          chk("event_kind", mon_kind, mon_e.kind);
          chk("event_occ", occupancy, mon_e.occ);
          if (mon_e.kind != 4) begin
            chk("grant_dir", gate_dir, (mon_e.kind == 2));
            chk("grant_gate_open", gate_open, 1);
          end
        end
      end
      if (gate_open) mon_run++;
      else if (mon_run > 0) begin
        if (len_q.size() == 0) chk("unexpected_window", mon_run, 0);
        else chk("window_len", mon_run, len_q.pop_front());
        mon_run = 0;
      end
    end
  end

  // One request attempt; k = window cycle carrying pass_done (k >= OPEN means none)
  task automatic txn(input logic er, input logic xr, input int k);
    bit  e_el, x_el, hit;
    int  dir;
    ev_t e;
    @(negedge clk);
    entry_req = er; exit_req = xr;
    #1;
    chk("entry_deny", entry_deny, (er && m_occ == CAP));
    e_el = er && (m_occ < CAP);
    x_el = xr && (m_occ > 0);
    if (!e_el && !x_el) begin
      pass_done = 1'b1;  // stray pulse in IDLE must be ignored
      @(negedge clk);
      pass_done = 1'b0;
      chk("no_grant_gate", gate_open, 0);
      entry_req = 0; exit_req = 0;
      chk("idle_occ", occupancy, m_occ);
      return;
    end
    if (e_el && x_el) dir = (m_last == 1) ? 0 : 1;
    else dir = e_el ? 0 : 1;
    m_last = dir;
    hit = (k >= 1 && k < OPEN);
    e.kind = (dir == 0) ? 1 : 2; e.occ = m_occ;
    ev_q.push_back(e);
    if (hit) len_q.push_back(k + 1);
    else begin
      len_q.push_back(OPEN);
      e.kind = 4; e.occ = m_occ;
      ev_q.push_back(e);
    end
    @(negedge clk);  // grant cycle
    entry_req = 0; exit_req = 0;
    for (int c = 1; c < OPEN; c++) begin
      @(negedge clk);
      if (c == k) begin
        pass_done = 1'b1;
        @(negedge clk);
        pass_done = 1'b0;
        break;
      end
    end
    if (!hit) @(negedge clk);  // close cycle
    if (hit) m_occ += (dir == 0) ? 1 : -1;
    @(negedge clk);  // back in IDLE
    chk("occupancy", occupancy, m_occ);
    chk("empty", empty, (m_occ == 0));
    chk("full", full, (m_occ == CAP));
    chk("closed_gate", gate_open, 0);
  endtask

  initial begin
    ev_t e;
    #1;
    chk("rst_gate_open", gate_open, 0);
    chk("rst_gate_dir", gate_dir, 0);
    chk("rst_entry_grant", entry_grant, 0);
    chk("rst_exit_grant", exit_grant, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_deny", entry_deny, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    #12 reset_n = 1'b1;

    // exit from an empty lot is refused
    txn(0, 1, 2);
    txn(0, 1, 3);
    // first entry, pass two cycles after grant
    txn(1, 0, 2);
    txn(1, 0, 3);
    txn(1, 0, 4);
    // held ties alternate lanes
    txn(1, 1, 2);
    txn(1, 1, 2);
    txn(1, 1, 2);
    // timeout, then pass in the last window cycle
    txn(1, 0, OPEN);
    txn(1, 0, OPEN - 1);
    // fill, deny, then drain one
    while (m_occ < CAP) txn(1, 0, $urandom_range(1, OPEN - 1));
    txn(1, 0, 2);
    txn(1, 1, 2);
    // randomized traffic
    repeat (200) txn(1'($urandom), 1'($urandom), $urandom_range(1, OPEN));

    // reset during an exit window with five cars present
    while (m_occ < 5) txn(1, 0, 1);
    while (m_occ > 5) txn(0, 1, 1);
    @(negedge clk);
    entry_req = 0; exit_req = 1;
    e.kind = 2; e.occ = m_occ;
    ev_q.push_back(e);
    @(negedge clk);
    exit_req = 0;
    @(negedge clk);
    chk("mid_gate_open", gate_open, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_gate_closed", gate_open, 0);
    chk("async_occ_clear", occupancy, 0);
    chk("async_no_timeout", timeout_err, 0);
    @(negedge clk);
    chk("rst_hold_timeout", timeout_err, 0);
    chk("evq_after_reset", ev_q.size(), 0);
    m_occ = 0; m_last = 1;
    #3 reset_n = 1'b1;
    txn(1, 1, 1);
    txn(1, 1, 1);
    txn(1, 1, OPEN);

    repeat (3) @(negedge clk);
    chk("events_drained", ev_q.size(), 0);
    chk("windows_drained", len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
